// File: rtl/nios2_ocimem_pkg.sv
// Shared types and jdo field positions for the OCI memory arbiter.
package nios2_ocimem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AV_WR,
    S_AV_RD,
    S_AV_RDATA,
    S_JT_WR,
    S_JT_RD,
    S_JT_RDATA
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

  typedef enum logic {
    GNT_AV,
    GNT_JT
  } grant_t;

  localparam int unsigned JDO_W    = 38;
  localparam int unsigned ADDR_LSB = 17;
  localparam int unsigned DATA_LSB = 3;
  localparam int unsigned RD_FLAG  = 34;

  function automatic logic is_jtag_state(input state_t s);
    return (s == S_JT_WR) || (s == S_JT_RD) || (s == S_JT_RDATA);
  endfunction

endpackage

// File: rtl/nios2_ocimem_arbiter.sv
// Arbitrates the single-port OCI RAM between the Avalon debug_mem slave
// and the JTAG debug command path, with round-robin on conflicts.
module nios2_ocimem_arbiter
  import nios2_ocimem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [DATA_W-1:0] av_writedata,
  input  logic [3:0]        av_byteenable,
  output logic [DATA_W-1:0] av_readdata,
  output logic              av_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteen,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              jtag_busy,
  output logic              jtag_overrun
);

  state_t              state_q, state_d;
  grant_t              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   jtag_addr_q, jtag_addr_d;
  logic                pend_valid_q, pend_valid_d;
  op_t                 pend_op_q, pend_op_d;
  logic [DATA_W-1:0]   pend_data_q, pend_data_d;
  logic [DATA_W-1:0]   jt_wdata_q, jt_wdata_d;
  logic [DATA_W-1:0]   mon_dreg_q, mon_dreg_d;
  logic                jtag_overrun_q, jtag_overrun_d;

  logic jt_active;
  logic jt_pulse;
  logic av_req;
  logic unused_jdo_bits;

  assign jt_active       = is_jtag_state(state_q);
  assign jt_pulse        = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign av_req          = av_read | av_write;
  assign unused_jdo_bits = ^{jdo[JDO_W-1:RD_FLAG+1], jdo[DATA_LSB-1:0]};

  // Next-state: arbitration, transaction sequencing and JTAG request capture.
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    jtag_addr_d    = jtag_addr_q;
    pend_valid_d   = pend_valid_q;
    pend_op_d      = pend_op_q;
    pend_data_d    = pend_data_q;
    jt_wdata_d     = jt_wdata_q;
    mon_dreg_d     = mon_dreg_q;
    jtag_overrun_d = jtag_overrun_q;

    case (state_q)
      S_IDLE: begin
        if (av_req && (!pend_valid_q || last_grant_q == GNT_JT)) begin
          state_d      = av_write ? S_AV_WR : S_AV_RD;
          last_grant_d = GNT_AV;
        end else if (pend_valid_q) begin
          // The op moves into service at grant so a pulse arriving during
          // service becomes a fresh pending op instead of being lost.
          state_d      = (pend_op_q == OP_WR) ? S_JT_WR : S_JT_RD;
          last_grant_d = GNT_JT;
          pend_valid_d = 1'b0;
          jt_wdata_d   = pend_data_q;
        end
      end
      S_AV_WR:    state_d = S_IDLE;
      S_AV_RD:    state_d = S_AV_RDATA;
      S_AV_RDATA: state_d = S_IDLE;
      S_JT_WR: begin
        state_d     = S_IDLE;
        jtag_addr_d = jtag_addr_q + ADDR_W'(1);
      end
      S_JT_RD:    state_d = S_JT_RDATA;
      S_JT_RDATA: begin
        state_d     = S_IDLE;
        mon_dreg_d  = ram_rdata;
        jtag_addr_d = jtag_addr_q + ADDR_W'(1);
      end
      default:    state_d = S_IDLE;
    endcase

    if (take_action_ocimem_a) jtag_addr_d = jdo[ADDR_LSB +: ADDR_W];
    if (jt_pulse && (pend_valid_q || jt_active)) jtag_overrun_d = 1'b1;

    if (take_action_ocimem_b) begin
      pend_valid_d = 1'b1;
      pend_op_d    = OP_WR;
      pend_data_d  = jdo[DATA_LSB +: DATA_W];
    end else if (take_no_action_ocimem_a || (take_action_ocimem_a && jdo[RD_FLAG])) begin
      pend_valid_d = 1'b1;
      pend_op_d    = OP_RD;
    end
  end

  // State and pending-request registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      last_grant_q   <= GNT_JT;
      jtag_addr_q    <= '0;
      pend_valid_q   <= 1'b0;
      pend_op_q      <= OP_RD;
      pend_data_q    <= '0;
      jt_wdata_q     <= '0;
      mon_dreg_q     <= '0;
      jtag_overrun_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      jtag_addr_q    <= jtag_addr_d;
      pend_valid_q   <= pend_valid_d;
      pend_op_q      <= pend_op_d;
      pend_data_q    <= pend_data_d;
      jt_wdata_q     <= jt_wdata_d;
      mon_dreg_q     <= mon_dreg_d;
      jtag_overrun_q <= jtag_overrun_d;
    end
  end

  // RAM and Avalon outputs decoded from the registered state.
  always_comb begin
    ram_addr       = av_address;
    ram_wren       = 1'b0;
    ram_byteen     = av_byteenable;
    ram_wdata      = av_writedata;
    av_waitrequest = 1'b1;
    av_readdata    = '0;
    case (state_q)
      S_AV_WR: begin
        ram_wren       = 1'b1;
        av_waitrequest = 1'b0;
      end
      S_AV_RDATA: begin
        av_readdata    = ram_rdata;
        av_waitrequest = 1'b0;
      end
      S_JT_WR: begin
        ram_addr   = jtag_addr_q;
        ram_wren   = 1'b1;
        ram_byteen = 4'hF;
        ram_wdata  = jt_wdata_q;
      end
      S_JT_RD, S_JT_RDATA: ram_addr = jtag_addr_q;
      default: ;
    endcase
  end

  assign MonDReg      = mon_dreg_q;
  assign jtag_busy    = pend_valid_q | jt_active;
  assign jtag_overrun = jtag_overrun_q;

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Bench for nios2_ocimem_arbiter: RAM model plus a reference memory image
// and expected JTAG address kept at transaction level.
module tb_nios2_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [7:0]  av_address;
  logic        av_read, av_write;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic [31:0] av_readdata;
  logic        av_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [3:0]  ram_byteen;
  logic [31:0] ram_wdata, ram_rdata;
  logic [31:0] MonDReg;
  logic        jtag_busy, jtag_overrun;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  int          wr_count = 0;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  logic [7:0]  exp_jaddr;

  always #5 clk = ~clk;

  nios2_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .av_address(av_address), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_byteenable(av_byteenable),
    .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_byteen(ram_byteen),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .MonDReg(MonDReg), .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun)
  );

  // Single-port RAM with one-cycle read latency and a bench preload port.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_wren) begin
      for (int b = 0; b < 4; b++)
        if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      wr_count <= wr_count + 1;
    end
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [37:0] jdo_addr(input logic [7:0] a, input logic rd);
    logic [37:0] j;
    j = '0;
    j[17 +: 8] = a;
    j[34] = rd;
    return j;
  endfunction

  function automatic logic [37:0] jdo_data(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[3 +: 32] = d;
    return j;
  endfunction

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d; ref_mem[a] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic av_op(input logic wr, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] be, output logic [31:0] rd, output int cyc);
    @(negedge clk);
    av_address = a; av_writedata = d; av_byteenable = be;
    av_write = wr; av_read = !wr;
    cyc = 0; rd = '0;
    for (int i = 0; i < 20; i++) begin
      #1;
      cyc++;
      if (!av_waitrequest) begin
        rd = av_readdata;
        break;
      end
      @(negedge clk);
    end
    av_write = 1'b0; av_read = 1'b0;
  endtask

  task automatic jt_pulse(input int kind, input logic [37:0] j);
    @(negedge clk);
    jdo = j;
    take_action_ocimem_a    = (kind == 0);
    take_no_action_ocimem_a = (kind == 1);
    take_action_ocimem_b    = (kind == 2);
    @(negedge clk);
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
  endtask

  task automatic jt_wait(output int cyc);
    cyc = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (!jtag_busy) break;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; av_read = 1'b1; av_address = 8'h10;
    @(negedge clk); #1;
    total++; if (av_waitrequest !== 1'b1) begin bad++; $display("FAIL reset_waitreq got=%b want=1", av_waitrequest); end
    total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL reset_wren got=%b want=0", ram_wren); end
    total++; if (MonDReg !== 32'h0) begin bad++; $display("FAIL reset_mondreg got=%h want=0", MonDReg); end
    total++; if (jtag_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", jtag_busy); end
    total++; if (jtag_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", jtag_overrun); end
    total++; if (av_readdata !== 32'h0) begin bad++; $display("FAIL reset_readdata got=%h want=0", av_readdata); end
    av_read = 1'b0;
    for (int a = 0; a < 256; a++) preload(8'(a), $urandom);
    @(negedge clk);
    reset_n = 1'b1;
    exp_jaddr = 8'h00;
  endtask

  task automatic test_av_basic();
    logic [31:0] rd, d;
    logic [7:0]  a;
    logic [3:0]  be;
    int cyc;
    av_op(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, rd, cyc);
    ref_mem[8'h10] = 32'hDEADBEEF;
    total++; if (cyc != 2) begin bad++; $display("FAIL av_wr_latency got=%0d want=2", cyc); end
    av_op(1'b0, 8'h10, '0, 4'h0, rd, cyc);
    total++; if (cyc != 3) begin bad++; $display("FAIL av_rd_latency got=%0d want=3", cyc); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL av_rd_data got=%h want=deadbeef", rd); end
    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom_range(0, 255)); d = $urandom; be = 4'($urandom_range(1, 15));
      av_op(1'b1, a, d, be, rd, cyc);
      ref_mem[a] = merge(ref_mem[a], d, be);
      av_op(1'b0, a, '0, 4'h0, rd, cyc);
      total++; if (rd !== ref_mem[a]) begin bad++; $display("FAIL av_rand_rd addr=%h got=%h want=%h", a, rd, ref_mem[a]); end
    end
  endtask

  task automatic test_jtag_read();
    int cyc;
    preload(8'h20, 32'h12345678);
    jt_pulse(0, jdo_addr(8'h20, 1'b1));
    exp_jaddr = 8'h20;
    jt_wait(cyc);
    total++; if (cyc != 3) begin bad++; $display("FAIL jt_rd_latency got=%0d want=3", cyc); end
    total++; if (MonDReg !== ref_mem[exp_jaddr]) begin bad++; $display("FAIL jt_rd_data got=%h want=%h", MonDReg, ref_mem[exp_jaddr]); end
    exp_jaddr++;
    jt_pulse(1, '0);
    jt_wait(cyc);
    total++; if (MonDReg !== ref_mem[exp_jaddr]) begin bad++; $display("FAIL jt_rd_incr got=%h want=%h", MonDReg, ref_mem[exp_jaddr]); end
    exp_jaddr++;
  endtask

  task automatic test_jtag_wrap();
    logic [31:0] d1, d2, rd;
    int cyc;
    d1 = $urandom; d2 = $urandom;
    jt_pulse(0, jdo_addr(8'hFF, 1'b0));
    exp_jaddr = 8'hFF;
    jt_pulse(2, jdo_data(d1));
    jt_wait(cyc);
    total++; if (cyc != 2) begin bad++; $display("FAIL jt_wr_latency got=%0d want=2", cyc); end
    ref_mem[exp_jaddr] = d1; exp_jaddr++;
    jt_pulse(2, jdo_data(d2));
    jt_wait(cyc);
    ref_mem[exp_jaddr] = d2; exp_jaddr++;
    av_op(1'b0, 8'hFF, '0, 4'h0, rd, cyc);
    total++; if (rd !== d1) begin bad++; $display("FAIL wrap_ff got=%h want=%h", rd, d1); end
    av_op(1'b0, 8'h00, '0, 4'h0, rd, cyc);
    total++; if (rd !== d2) begin bad++; $display("FAIL wrap_00 got=%h want=%h", rd, d2); end
    jt_pulse(1, '0);
    jt_wait(cyc);
    total++; if (MonDReg !== ref_mem[8'h01]) begin bad++; $display("FAIL wrap_addr1 got=%h want=%h", MonDReg, ref_mem[8'h01]); end
    exp_jaddr++;
    total++; if (jtag_overrun !== 1'b0) begin bad++; $display("FAIL no_overrun got=%b want=0", jtag_overrun); end
  endtask

  // Avalon reads held continuously while JTAG reads are re-issued as soon
  // as JTAG goes idle: grants must alternate, starting with Avalon.
  task automatic test_arbitration();
    logic expect_av, prev_busy, done;
    int na, nj;
    expect_av = 1'b1; prev_busy = 1'b0; done = 1'b0; na = 0; nj = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk); #1;
      if (av_read && !av_waitrequest) begin
        total++; if (!expect_av) begin bad++; $display("FAIL arb_order got=AV want=JTAG cycle=%0d", c); end
        total++; if (av_readdata !== ref_mem[av_address]) begin bad++; $display("FAIL arb_av_data got=%h want=%h", av_readdata, ref_mem[av_address]); end
        expect_av = 1'b0; na++;
        if (c >= 40) av_read = 1'b0;
        else av_address = 8'($urandom);
      end
      if (prev_busy && !jtag_busy) begin
        total++; if (expect_av) begin bad++; $display("FAIL arb_order got=JTAG want=AV cycle=%0d", c); end
        total++; if (MonDReg !== ref_mem[exp_jaddr]) begin bad++; $display("FAIL arb_jt_data got=%h want=%h", MonDReg, ref_mem[exp_jaddr]); end
        exp_jaddr++; expect_av = 1'b1; nj++;
      end
      prev_busy = jtag_busy;
      take_no_action_ocimem_a = 1'b0;
      if (c == 1) begin av_address = 8'($urandom); av_read = 1'b1; end
      if (!jtag_busy && c < 40) begin take_no_action_ocimem_a = 1'b1; prev_busy = 1'b1; end
      if (c >= 40 && !av_read && !jtag_busy) done = 1'b1;
    end
    take_no_action_ocimem_a = 1'b0; av_read = 1'b0;
    total++; if (na < 4 || nj < 4) begin bad++; $display("FAIL arb_activity got=av%0d/jt%0d want>=4 each", na, nj); end
  endtask

  task automatic test_overrun();
    logic [31:0] d1, d2, rd;
    logic [7:0]  a0;
    int cyc, w0;
    a0 = 8'($urandom); d1 = $urandom; d2 = ~d1;
    jt_pulse(0, jdo_addr(a0, 1'b0));
    exp_jaddr = a0;
    total++; if (jtag_overrun !== 1'b0) begin bad++; $display("FAIL ovr_pre got=%b want=0", jtag_overrun); end
    w0 = wr_count;
    @(negedge clk); av_address = 8'($urandom); av_read = 1'b1;
    @(negedge clk); jdo = jdo_data(d1); take_action_ocimem_b = 1'b1;
    @(negedge clk); jdo = jdo_data(d2); av_read = 1'b0;
    @(negedge clk); take_action_ocimem_b = 1'b0;
    jt_wait(cyc);
    ref_mem[exp_jaddr] = d2; exp_jaddr++;
    total++; if (jtag_overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b want=1", jtag_overrun); end
    total++; if (wr_count - w0 != 1) begin bad++; $display("FAIL ovr_writes got=%0d want=1", wr_count - w0); end
    av_op(1'b0, a0, '0, 4'h0, rd, cyc);
    total++; if (rd !== d2) begin bad++; $display("FAIL ovr_data got=%h want=%h", rd, d2); end
  endtask

  task automatic test_reset_abort();
    int w0, cyc;
    w0 = wr_count;
    jt_pulse(2, jdo_data($urandom));
    #1;
    total++; if (jtag_busy !== 1'b1) begin bad++; $display("FAIL abort_pending got=%b want=1", jtag_busy); end
    reset_n = 1'b0; av_read = 1'b1; av_address = 8'h33;
    #1;
    total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL abort_wren got=%b want=0", ram_wren); end
    total++; if (jtag_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", jtag_busy); end
    total++; if (jtag_overrun !== 1'b0) begin bad++; $display("FAIL abort_overrun got=%b want=0", jtag_overrun); end
    total++; if (MonDReg !== 32'h0) begin bad++; $display("FAIL abort_mondreg got=%h want=0", MonDReg); end
    total++; if (av_waitrequest !== 1'b1) begin bad++; $display("FAIL abort_waitreq got=%b want=1", av_waitrequest); end
    repeat (3) @(negedge clk);
    av_read = 1'b0; reset_n = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (wr_count != w0) begin bad++; $display("FAIL abort_no_write got=%0d want=%0d", wr_count, w0); end
    exp_jaddr = 8'h00;
    jt_pulse(1, '0);
    jt_wait(cyc);
    total++; if (MonDReg !== ref_mem[exp_jaddr]) begin bad++; $display("FAIL abort_jaddr0 got=%h want=%h", MonDReg, ref_mem[exp_jaddr]); end
  endtask

  initial begin
    jdo = '0;
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    av_address = '0; av_read = 1'b0; av_write = 1'b0; av_writedata = '0; av_byteenable = '0;
    reset_n = 1'b0;
    test_reset();
    test_av_basic();
    test_jtag_read();
    test_jtag_wrap();
    test_arbitration();
    test_overrun();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
